// File: rtl/niosii_system_gear_sel_in_pkg.sv
// Shared definitions for the gear-selector input peripheral:
// register offsets, bus width and the bus write-strobe decode.
package niosii_system_gear_sel_in_pkg;

    localparam int unsigned BUS_W = 32;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_RSVD    = 2'd1,
        REG_IRQMASK = 2'd2,
        REG_EDGECAP = 2'd3
    } reg_addr_e;

    function automatic logic is_write(
        input logic cs,
        input logic wr_n
    );
        return cs & ~wr_n;
    endfunction

endpackage

// File: rtl/niosii_system_gear_sel_in_if.sv
// Avalon-MM slave bundle for the gear-selector peripheral.
// master: address/chipselect/write_n/writedata out; slave: readdata/irq out.
interface niosii_system_gear_sel_in_if;
    import niosii_system_gear_sel_in_pkg::*;

    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [BUS_W-1:0] writedata;
    logic [BUS_W-1:0] readdata;
    logic             irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

endinterface

// File: rtl/niosii_system_gear_debounce.sv
// Two-flop synchronizer plus whole-vector debouncer.
// Ports: clk, reset (sync, active-high), raw (async in), clean (debounced out).
module niosii_system_gear_debounce #(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean
);

    localparam int unsigned CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             match;

    assign match = (sync2 == cand);

    // Any difference restarts the count; matches saturate at CNT_MAX.
    always_comb begin
        cnt_next = '0;
        if (match) begin
            if (cnt == CNT_MAX) begin
                cnt_next = cnt;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
            clean <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cnt   <= cnt_next;
            if (!match) begin
                cand <= sync2;
            end
            // Accept once the candidate has been stable long enough.
            if (match && (cnt_next == CNT_MAX)) begin
                clean <= cand;
            end
        end
    end

endmodule

// File: rtl/niosii_system_gear_sel_in.sv
// Gear-selector input port: debounced DATA, IRQMASK, EDGECAP and irq.
// Ports: clk, reset (sync, active-high), in_port (raw lines), bus (Avalon slave).
module niosii_system_gear_sel_in
    import niosii_system_gear_sel_in_pkg::*;
#(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in_port,
    niosii_system_gear_sel_in_if.slave   bus
);

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] wdata;
    logic [BUS_W-1:0] rdata;
    logic             wr_en;
    logic             irq_q;
    logic             unused_wdata;

    niosii_system_gear_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (in_port),
        .clean (data)
    );

    assign wr_en        = is_write(bus.chipselect, bus.write_n);
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    // data_q resets alongside data, so reset never looks like an edge.
    assign edge_set = data ^ data_q;

    always_comb begin
        edge_clr = '0;
        if (wr_en && (bus.address == REG_EDGECAP)) begin
            edge_clr = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            irq_q    <= 1'b0;
        end else begin
            data_q <= data;
            if (wr_en && (bus.address == REG_IRQMASK)) begin
                irq_mask <= wdata;
            end
            // Set after clear: a coincident edge keeps the bit.
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
            irq_q    <= |(edge_cap & irq_mask);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (reg_addr_e'(bus.address))
            REG_DATA:    rdata[WIDTH-1:0] = data;
            REG_RSVD:    rdata = '0;
            REG_IRQMASK: rdata[WIDTH-1:0] = irq_mask;
            REG_EDGECAP: rdata[WIDTH-1:0] = edge_cap;
        endcase
    end

    assign bus.readdata = rdata;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_niosii_system_gear_sel_in.sv
// Directed bench for the gear-selector input port.
// Default parameters: WIDTH=2, DEBOUNCE_CYCLES=16.
module tb_niosii_system_gear_sel_in;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_port;
    int         errors = 0;
    int         checks = 0;

    niosii_system_gear_sel_in_if bus ();

    niosii_system_gear_sel_in #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(
        input string       tag,
        input logic [1:0]  a,
        input logic [31:0] exp
    );
        bus.address = a;
        #1;
        check(tag, bus.readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    initial begin
        reset          = 1'b1;
        in_port        = 2'b00;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // reset state
        chk_reg("rst_data", 2'd0, 32'd0);
        chk_reg("rst_rsvd", 2'd1, 32'd0);
        chk_reg("rst_mask", 2'd2, 32'd0);
        chk_reg("rst_ecap", 2'd3, 32'd0);
        check("rst_irq", bus.irq, 1'b0);

        // 00->10 step: DATA changes 18 clocks later
        in_port = 2'b10;
        tick(17);
        chk_reg("step_d17", 2'd0, 32'd0);
        tick(1);
        chk_reg("step_d18", 2'd0, 32'd2);
        chk_reg("step_ec18", 2'd3, 32'd0);
        tick(1);
        chk_reg("step_ec19", 2'd3, 32'd2);
        check("step_irq", bus.irq, 1'b0);
        wr(2'd3, 32'd3);
        chk_reg("w1c_all", 2'd3, 32'd0);

        // write to DATA / reserved is ignored
        wr(2'd0, 32'd1);
        wr(2'd1, 32'd3);
        chk_reg("ro_data", 2'd0, 32'd2);
        chk_reg("ro_rsvd", 2'd1, 32'd0);

        // back to 00
        in_port = 2'b00;
        tick(20);
        chk_reg("back_data", 2'd0, 32'd0);
        chk_reg("back_ecap", 2'd3, 32'd2);
        wr(2'd3, 32'hFFFF_FFFF);
        chk_reg("back_clr", 2'd3, 32'd0);

        // 10-clock glitch
        in_port = 2'b01;
        tick(10);
        in_port = 2'b00;
        tick(30);
        chk_reg("gl10_data", 2'd0, 32'd0);
        chk_reg("gl10_ecap", 2'd3, 32'd0);

        // 15-clock glitch, one short of acceptance
        in_port = 2'b01;
        tick(15);
        in_port = 2'b00;
        tick(30);
        chk_reg("gl15_data", 2'd0, 32'd0);
        chk_reg("gl15_ecap", 2'd3, 32'd0);

        // mask bit 1, 00->11
        wr(2'd2, 32'hFFFF_FFFE);
        chk_reg("mask_rd", 2'd2, 32'd2);
        in_port = 2'b11;
        tick(20);
        chk_reg("m11_data", 2'd0, 32'd3);
        chk_reg("m11_ecap", 2'd3, 32'd3);
        check("m11_irq", bus.irq, 1'b1);
        wr(2'd3, 32'd2);
        chk_reg("m11_w1c", 2'd3, 32'd1);
        check("irq_regd", bus.irq, 1'b1);
        tick(1);
        check("irq_drop", bus.irq, 1'b0);

        // clear coinciding with bit-0 set: set wins
        wr(2'd3, 32'd3);
        chk_reg("coin_pre", 2'd3, 32'd0);
        in_port = 2'b10;
        tick(18);
        chk_reg("coin_data", 2'd0, 32'd2);
        wr(2'd3, 32'd1);
        chk_reg("coin_ecap", 2'd3, 32'd1);
        check("coin_irq", bus.irq, 1'b0);
        wr(2'd3, 32'd1);
        chk_reg("coin_clr", 2'd3, 32'd0);

        // reset mid-debounce
        in_port = 2'b00;
        tick(20);
        wr(2'd3, 32'd3);
        in_port = 2'b11;
        tick(8);
        reset = 1'b1;
        tick(2);
        chk_reg("mid_data", 2'd0, 32'd0);
        chk_reg("mid_ecap", 2'd3, 32'd0);
        chk_reg("mid_mask", 2'd2, 32'd0);
        check("mid_irq", bus.irq, 1'b0);
        reset = 1'b0;
        tick(17);
        chk_reg("rel_d17", 2'd0, 32'd0);
        chk_reg("rel_ec17", 2'd3, 32'd0);
        tick(1);
        chk_reg("rel_d18", 2'd0, 32'd3);
        tick(1);
        chk_reg("rel_ecap", 2'd3, 32'd3);
        check("rel_irq", bus.irq, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/niosii_system_gear_sel_in.md
NIOSII_SYSTEM_GEAR_SEL_IN -- requirements
Module: niosII_system_gear_sel_in

Interface
REQ-001 Parameter WIDTH, default 2, width of the gear-selector input vector.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable clocks required before the input is accepted; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 address  input  2  Avalon-MM word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 in_port  input  WIDTH  raw, asynchronous gear-selector lines.
REQ-010 readdata  output  32  read data, zero-extended.
REQ-011 irq  output  1  level interrupt request, active-high.

Function
REQ-012 Register map SHALL be: 0 = DATA (RO, debounced value), 1 = reserved (reads 0, writes ignored), 2 = IRQMASK (RW, WIDTH bits), 3 = EDGECAP (read; write-1-to-clear).
REQ-013 readdata SHALL be combinational from address, zero wait states, read latency 0; bits above WIDTH SHALL read 0.
REQ-014 A write SHALL occur only when chipselect=1 and write_n=0; only writedata[WIDTH-1:0] SHALL be used.
REQ-015 in_port SHALL pass through a two-flop synchronizer before any other use.
REQ-016 The debouncer SHALL hold a candidate value and a stability counter; any clock where the synchronized input differs from the candidate SHALL load the candidate and clear the counter.
REQ-017 When the synchronized input equals the candidate, the counter SHALL increment, saturating at DEBOUNCE_CYCLES-1.
REQ-018 The debounced value SHALL update to the candidate on the clock the counter reaches DEBOUNCE_CYCLES-1 with matching input; total latency from a clean in_port step to DATA change SHALL be 2 + DEBOUNCE_CYCLES clocks.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized clocks SHALL NOT change DATA.
REQ-020 Debounce SHALL operate on the whole vector: any bit change restarts the counter.
REQ-021 EDGECAP bit n SHALL set on the clock after debounced bit n changes in either direction.
REQ-022 A write of 1 to EDGECAP bit n SHALL clear it; a write of 0 SHALL leave it unchanged.
REQ-023 If a set and a clear of the same EDGECAP bit coincide, set SHALL win.
REQ-024 irq SHALL be registered: irq = OR of (EDGECAP & IRQMASK), one clock after either register changes.
REQ-025 Writes to DATA or reserved address SHALL have no effect.

Reset
REQ-026 On reset: synchronizer flops, candidate, debounced DATA = 0; counter = 0; IRQMASK = 0; EDGECAP = 0; irq = 0.
REQ-027 Reset asserted mid-debounce SHALL abandon the pending candidate; no EDGECAP bit SHALL set due to the reset transition itself.
REQ-028 After reset release with in_port nonzero, DATA SHALL follow REQ-018 and the resulting 0-to-1 change SHALL set EDGECAP.

Structure
REQ-029 Register-offset constants (DATA=0, IRQMASK=2, EDGECAP=3) SHALL live in the shared system package/include.
REQ-030 The synchronizer and debouncer SHALL be one sub-module, niosII_system_gear_debounce (WIDTH, DEBOUNCE_CYCLES parameters; clk, reset, raw in, clean out).
REQ-031 Register file, edge detect and irq logic SHALL reside in the top module.

Verification
REQ-032 Reset, in_port=2'b00, read addr 0/2/3 -> readdata 0, irq 0.
REQ-033 DEBOUNCE_CYCLES=16, in_port 00->10 held -> DATA reads 2 exactly 18 clocks after the step, EDGECAP reads 2.
REQ-034 in_port 00->01 for 10 clocks then back to 00 -> DATA stays 0, EDGECAP stays 0.
REQ-035 IRQMASK=2'b10, debounced 00->11 -> EDGECAP=3, irq=1; write EDGECAP=2'b10 -> EDGECAP=1, irq=0 next clock.
REQ-036 Write-1-to-clear EDGECAP bit 0 on the same clock bit 0 edge sets -> EDGECAP bit 0 remains 1.
REQ-037 Reset asserted 8 clocks into a 00->11 debounce, released with in_port=11 -> DATA=3 exactly 18 clocks after release, EDGECAP=3.
